// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: funct3 access sizes, handshake FSM states,
// byte-enable and alignment helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } f3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RSP  = 2'b10
    } state_e;

    // Byte enables for an 8-byte bus; narrower buses take the low bits.
    function automatic logic [7:0] bmask_f(input logic [2:0] f3, input logic [2:0] addr_lo);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01 << addr_lo;
            2'b01:   m = 8'h03 << addr_lo;
            2'b10:   m = 8'h0F << addr_lo;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic aligned_f(input logic [2:0] f3, input logic [2:0] addr_lo);
        logic a;
        case (f3[1:0])
            2'b00:   a = 1'b1;
            2'b01:   a = (addr_lo[0] == 1'b0);
            2'b10:   a = (addr_lo[1:0] == 2'b00);
            2'b11:   a = (addr_lo == 3'b000);
            default: a = 1'b0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte enables, plus load
// byte/half/word extraction with sign or zero extension.
module lsu_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                   i_f3,
    input  logic [$clog2(XLEN/8)-1:0]    i_addr_lo,
    input  logic [XLEN-1:0]              i_rs2,
    input  logic [XLEN-1:0]              i_rdata,
    output logic [XLEN-1:0]              o_wdata,
    output logic [XLEN/8-1:0]            o_bmask,
    output logic [XLEN-1:0]              o_ld_data
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted_s;

    assign o_bmask   = NB'(bmask_f(i_f3, 3'(i_addr_lo)));
    assign shifted_s = i_rdata >> {i_addr_lo, 3'b000};

    // Replicate the store operand into every lane of its size.
    always_comb begin
        o_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            case (i_f3[1:0])
                2'b00:   o_wdata[i*8 +: 8] = i_rs2[7:0];
                2'b01:   o_wdata[i*8 +: 8] = i_rs2[(i % 2)*8 +: 8];
                2'b10:   o_wdata[i*8 +: 8] = i_rs2[(i % 4)*8 +: 8];
                default: o_wdata[i*8 +: 8] = i_rs2[i*8 +: 8];
            endcase
        end
    end

    // Pick the addressed field out of the read data and extend it.
    always_comb begin
        case (i_f3)
            F3_B:    o_ld_data = XLEN'($signed(shifted_s[7:0]));
            F3_H:    o_ld_data = XLEN'($signed(shifted_s[15:0]));
            F3_W:    o_ld_data = XLEN'($signed(shifted_s[31:0]));
            F3_D:    o_ld_data = shifted_s;
            F3_BU:   o_ld_data = XLEN'(shifted_s[7:0]);
            F3_HU:   o_ld_data = XLEN'(shifted_s[15:0]);
            F3_WU:   o_ld_data = XLEN'(shifted_s[31:0]);
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a request/grant/response data-memory handshake, bounded wait,
// misalignment detection and the MEM/WB pipeline register.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_mem_insn_vld,
    input  logic [XLEN-1:0]      i_mem_pc,
    input  logic [31:0]          i_mem_inst,
    input  logic [XLEN-1:0]      i_mem_alu_data,
    input  logic [XLEN-1:0]      i_mem_rs2_data,
    input  logic                 i_mem_lsu_wren,
    input  logic                 i_mem_lsu_rden,
    input  logic [2:0]           i_mem_slt_sl,
    input  logic [1:0]           i_mem_wb_sel,
    input  logic                 i_mem_rd_wren,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [XLEN-1:0]      o_dmem_addr,
    output logic [XLEN-1:0]      o_dmem_wdata,
    output logic [XLEN/8-1:0]    o_dmem_bmask,
    input  logic                 i_dmem_gnt,
    input  logic                 i_dmem_rvalid,
    input  logic [XLEN-1:0]      i_dmem_rdata,
    output logic                 o_mem_stall,
    output logic [4:0]           o_mem_rd_addr_fwd,
    output logic                 o_mem_misalign,
    output logic                 o_mem_timeout,
    output logic [XLEN-1:0]      o_wb_pc_add4,
    output logic [XLEN-1:0]      o_wb_alu_data,
    output logic [XLEN-1:0]      o_wb_ld_data,
    output logic [XLEN-1:0]      o_wb_pc_debug,
    output logic [31:0]          o_wb_inst,
    output logic [1:0]           o_wb_sel,
    output logic                 o_wb_rd_wren,
    output logic                 o_wb_insn_vld
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_mem_s, aligned_s, acc_s, misalign_now_s;
    logic              req_s, complete_s, timeout_now_s, stall_s;
    logic [XLEN-1:0]   ld_ext_s;

    logic [XLEN-1:0]   pc_add4_q, pc_add4_d;
    logic [XLEN-1:0]   alu_data_q, alu_data_d;
    logic [XLEN-1:0]   ld_data_q, ld_data_d;
    logic [XLEN-1:0]   pc_debug_q, pc_debug_d;
    logic [31:0]       inst_q, inst_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic              rd_wren_q, rd_wren_d;
    logic              insn_vld_q, insn_vld_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    assign is_mem_s       = i_mem_insn_vld & (i_mem_lsu_wren | i_mem_lsu_rden);
    assign aligned_s      = aligned_f(i_mem_slt_sl, i_mem_alu_data[2:0]);
    assign acc_s          = is_mem_s & aligned_s;
    assign misalign_now_s = is_mem_s & ~aligned_s;
    assign stall_s        = acc_s & ~complete_s;

    lsu_align #(
        .XLEN (XLEN)
    ) u_lsu_align (
        .i_f3      (i_mem_slt_sl),
        .i_addr_lo (i_mem_alu_data[OFF_W-1:0]),
        .i_rs2     (i_mem_rs2_data),
        .i_rdata   (i_dmem_rdata),
        .o_wdata   (o_dmem_wdata),
        .o_bmask   (o_dmem_bmask),
        .o_ld_data (ld_ext_s)
    );

    // Handshake FSM and REQ+RSP wait counter; abort fires on the MAX_WAIT-th waiting cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_s         = 1'b0;
        complete_s    = 1'b0;
        timeout_now_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (acc_s) begin
                    req_s = 1'b1;
                    if (!i_dmem_gnt) begin
                        state_d = ST_REQ;
                    end else if (i_mem_lsu_rden) begin
                        state_d = ST_RSP;
                    end else begin
                        complete_s = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                req_s = 1'b1;
                if (i_dmem_gnt && !i_mem_lsu_rden) begin
                    complete_s = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    complete_s    = 1'b1;
                    timeout_now_s = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end else if (i_dmem_gnt) begin
                    state_d = ST_RSP;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RSP: begin
                if (i_dmem_rvalid) begin
                    complete_s = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    complete_s    = 1'b1;
                    timeout_now_s = 1'b1;
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MEM/WB capture on completion or non-access; a stalled cycle retires as a bubble.
    always_comb begin
        pc_add4_d  = pc_add4_q;
        alu_data_d = alu_data_q;
        ld_data_d  = ld_data_q;
        pc_debug_d = pc_debug_q;
        inst_d     = inst_q;
        wb_sel_d   = wb_sel_q;
        rd_wren_d  = 1'b0;
        insn_vld_d = 1'b0;
        if (!stall_s) begin
            pc_add4_d  = i_mem_pc + XLEN'(4);
            alu_data_d = i_mem_alu_data;
            ld_data_d  = timeout_now_s ? '0 : ld_ext_s;
            pc_debug_d = i_mem_pc;
            inst_d     = i_mem_inst;
            wb_sel_d   = i_mem_wb_sel;
            rd_wren_d  = i_mem_rd_wren & ~misalign_now_s;
            insn_vld_d = i_mem_insn_vld & ~misalign_now_s;
        end else begin
            rd_wren_d  = 1'b0;
            insn_vld_d = 1'b0;
        end
        misalign_d = misalign_q | misalign_now_s;
        timeout_d  = timeout_q | timeout_now_s;
    end

    // State, counter, sticky flags and MEM/WB register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pc_add4_q  <= '0;
            alu_data_q <= '0;
            ld_data_q  <= '0;
            pc_debug_q <= '0;
            inst_q     <= 32'h0000_0000;
            wb_sel_q   <= 2'b00;
            rd_wren_q  <= 1'b0;
            insn_vld_q <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_add4_q  <= pc_add4_d;
            alu_data_q <= alu_data_d;
            ld_data_q  <= ld_data_d;
            pc_debug_q <= pc_debug_d;
            inst_q     <= inst_d;
            wb_sel_q   <= wb_sel_d;
            rd_wren_q  <= rd_wren_d;
            insn_vld_q <= insn_vld_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_dmem_req        = req_s;
    assign o_dmem_we         = i_mem_lsu_wren;
    assign o_dmem_addr       = {i_mem_alu_data[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign o_mem_stall       = stall_s;
    assign o_mem_rd_addr_fwd = i_mem_inst[11:7];
    assign o_mem_misalign    = misalign_q;
    assign o_mem_timeout     = timeout_q;
    assign o_wb_pc_add4      = pc_add4_q;
    assign o_wb_alu_data     = alu_data_q;
    assign o_wb_ld_data      = ld_data_q;
    assign o_wb_pc_debug     = pc_debug_q;
    assign o_wb_inst         = inst_q;
    assign o_wb_sel          = wb_sel_q;
    assign o_wb_rd_wren      = rd_wren_q;
    assign o_wb_insn_vld     = insn_vld_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs: a 32-bit instance for the handshake scenarios and a
// 64-bit instance for doubleword / upper-word loads.
module tb_mem_stage_hs;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 32-bit instance
    logic        vld, wren, rden, rd_wren, gnt, rvalid;
    logic [31:0] pc, inst, alu, rs2, rdata;
    logic [2:0]  f3;
    logic [1:0]  wb_sel;
    logic        dreq, dwe, stall, misal, tmo, wb_rdw, wb_vld;
    logic [31:0] daddr, dwdata, wb_pc4, wb_alu, wb_ld, wb_pcd, wb_inst;
    logic [3:0]  dbm;
    logic [4:0]  rd_fwd;
    logic [1:0]  wb_sel_o;

    // 64-bit instance
    logic        d_vld, d_rden, d_gnt, d_rvalid;
    logic [63:0] d_alu, d_rdata;
    logic [2:0]  d_f3;
    logic        d_dreq, d_dwe, d_stall, d_misal, d_tmo, d_wb_rdw, d_wb_vld;
    logic [63:0] d_daddr, d_dwdata, d_wb_pc4, d_wb_alu, d_wb_ld, d_wb_pcd;
    logic [31:0] d_wb_inst;
    logic [7:0]  d_dbm;
    logic [4:0]  d_rd_fwd;
    logic [1:0]  d_wb_sel_o;

    mem_stage_hs #(.XLEN(32), .MAX_WAIT(15)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_mem_insn_vld(vld), .i_mem_pc(pc), .i_mem_inst(inst),
        .i_mem_alu_data(alu), .i_mem_rs2_data(rs2),
        .i_mem_lsu_wren(wren), .i_mem_lsu_rden(rden), .i_mem_slt_sl(f3),
        .i_mem_wb_sel(wb_sel), .i_mem_rd_wren(rd_wren),
        .o_dmem_req(dreq), .o_dmem_we(dwe), .o_dmem_addr(daddr),
        .o_dmem_wdata(dwdata), .o_dmem_bmask(dbm),
        .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_mem_stall(stall), .o_mem_rd_addr_fwd(rd_fwd),
        .o_mem_misalign(misal), .o_mem_timeout(tmo),
        .o_wb_pc_add4(wb_pc4), .o_wb_alu_data(wb_alu), .o_wb_ld_data(wb_ld),
        .o_wb_pc_debug(wb_pcd), .o_wb_inst(wb_inst), .o_wb_sel(wb_sel_o),
        .o_wb_rd_wren(wb_rdw), .o_wb_insn_vld(wb_vld)
    );

    mem_stage_hs #(.XLEN(64), .MAX_WAIT(15)) dut64 (
        .i_clk(clk), .i_reset(rst),
        .i_mem_insn_vld(d_vld), .i_mem_pc(64'h0000_0000_0000_2000), .i_mem_inst(32'h0000_0083),
        .i_mem_alu_data(d_alu), .i_mem_rs2_data(64'h0),
        .i_mem_lsu_wren(1'b0), .i_mem_lsu_rden(d_rden), .i_mem_slt_sl(d_f3),
        .i_mem_wb_sel(2'b01), .i_mem_rd_wren(1'b1),
        .o_dmem_req(d_dreq), .o_dmem_we(d_dwe), .o_dmem_addr(d_daddr),
        .o_dmem_wdata(d_dwdata), .o_dmem_bmask(d_dbm),
        .i_dmem_gnt(d_gnt), .i_dmem_rvalid(d_rvalid), .i_dmem_rdata(d_rdata),
        .o_mem_stall(d_stall), .o_mem_rd_addr_fwd(d_rd_fwd),
        .o_mem_misalign(d_misal), .o_mem_timeout(d_tmo),
        .o_wb_pc_add4(d_wb_pc4), .o_wb_alu_data(d_wb_alu), .o_wb_ld_data(d_wb_ld),
        .o_wb_pc_debug(d_wb_pcd), .o_wb_inst(d_wb_inst), .o_wb_sel(d_wb_sel_o),
        .o_wb_rd_wren(d_wb_rdw), .o_wb_insn_vld(d_wb_vld)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        vld = 1'b0; wren = 1'b0; rden = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        f3 = 3'b000; alu = 32'h0; rs2 = 32'h0; rdata = 32'h0;
    endtask

    initial begin
        idle32();
        pc = 32'h0; inst = 32'h0; wb_sel = 2'b00; rd_wren = 1'b0;
        d_vld = 1'b0; d_rden = 1'b0; d_gnt = 1'b0; d_rvalid = 1'b0;
        d_alu = 64'h0; d_rdata = 64'h0; d_f3 = 3'b000;
        rst = 1'b1;
        #12;
        check_eq("rst_wb_vld", {63'h0, wb_vld}, 64'h0);
        check_eq("rst_misalign", {63'h0, misal}, 64'h0);
        check_eq("rst_timeout", {63'h0, tmo}, 64'h0);
        check_eq("rst_wb_pc4", {32'h0, wb_pc4}, 64'h0);
        rst = 1'b0;
        tick();

        // 1: ALU op, no memory access
        vld = 1'b1; pc = 32'h100; inst = 32'h0000_0A93; alu = 32'h1234;
        wb_sel = 2'b01; rd_wren = 1'b1;
        #1;
        check_eq("alu_stall", {63'h0, stall}, 64'h0);
        check_eq("alu_req", {63'h0, dreq}, 64'h0);
        check_eq("rd_fwd", {59'h0, rd_fwd}, 64'd21);
        tick();
        check_eq("alu_wb_data", {32'h0, wb_alu}, 64'h1234);
        check_eq("alu_wb_vld", {63'h0, wb_vld}, 64'h1);
        check_eq("alu_wb_pc4", {32'h0, wb_pc4}, 64'h104);
        check_eq("alu_wb_pcd", {32'h0, wb_pcd}, 64'h100);
        check_eq("alu_wb_sel", {62'h0, wb_sel_o}, 64'h1);

        // 2: lb at 0x103, gnt at cycle 0, rvalid at cycle 2
        idle32(); vld = 1'b1; rden = 1'b1; f3 = 3'b000; alu = 32'h103; gnt = 1'b1;
        #1;
        check_eq("lb_req_c0", {63'h0, dreq}, 64'h1);
        check_eq("lb_addr", {32'h0, daddr}, 64'h100);
        check_eq("lb_stall_c0", {63'h0, stall}, 64'h1);
        tick();
        gnt = 1'b0;
        #1;
        check_eq("lb_stall_c1", {63'h0, stall}, 64'h1);
        check_eq("lb_req_c1", {63'h0, dreq}, 64'h0);
        check_eq("lb_bubble", {63'h0, wb_vld}, 64'h0);
        tick();
        rvalid = 1'b1; rdata = 32'h80FF_FF00;
        #1;
        check_eq("lb_stall_c2", {63'h0, stall}, 64'h0);
        tick();
        idle32();
        check_eq("lb_ld_data", {32'h0, wb_ld}, 64'hFFFF_FF80);
        check_eq("lb_wb_vld", {63'h0, wb_vld}, 64'h1);

        // 3: sh at 0x102, gnt delayed 3 cycles
        idle32(); vld = 1'b1; wren = 1'b1; f3 = 3'b001; alu = 32'h102; rs2 = 32'h0000_ABCD;
        for (int i = 0; i < 4; i++) begin
            gnt = (i == 3);
            #1;
            check_eq("sh_req", {63'h0, dreq}, 64'h1);
            check_eq("sh_we", {63'h0, dwe}, 64'h1);
            check_eq("sh_bmask", {60'h0, dbm}, 64'hC);
            check_eq("sh_wdata", {32'h0, dwdata}, 64'hABCD_ABCD);
            check_eq("sh_stall", {63'h0, stall}, (i < 3) ? 64'h1 : 64'h0);
            tick();
        end
        idle32();
        check_eq("sh_wb_vld", {63'h0, wb_vld}, 64'h1);

        // 4: misaligned lw at 0x101
        vld = 1'b1; rden = 1'b1; f3 = 3'b010; alu = 32'h101;
        #1;
        check_eq("mis_req", {63'h0, dreq}, 64'h0);
        check_eq("mis_stall", {63'h0, stall}, 64'h0);
        tick();
        idle32();
        check_eq("mis_flag", {63'h0, misal}, 64'h1);
        check_eq("mis_rd_wren", {63'h0, wb_rdw}, 64'h0);
        check_eq("mis_wb_vld", {63'h0, wb_vld}, 64'h0);

        // 5: load granted, never answered -> timeout after 15 waiting cycles
        vld = 1'b1; rden = 1'b1; f3 = 3'b010; alu = 32'h200; rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            gnt = (i == 0);
            #1;
            check_eq("tmo_stall", {63'h0, stall}, (i < 15) ? 64'h1 : 64'h0);
            tick();
        end
        idle32();
        check_eq("tmo_flag", {63'h0, tmo}, 64'h1);
        check_eq("tmo_ld_zero", {32'h0, wb_ld}, 64'h0);
        check_eq("tmo_wb_vld", {63'h0, wb_vld}, 64'h1);

        // 6: reset while in RSP, late rvalid ignored
        vld = 1'b1; rden = 1'b1; f3 = 3'b010; alu = 32'h300; gnt = 1'b1;
        tick();
        idle32();
        #2 rst = 1'b1;
        #1;
        check_eq("rsp_rst_vld", {63'h0, wb_vld}, 64'h0);
        check_eq("rsp_rst_tmo", {63'h0, tmo}, 64'h0);
        check_eq("rsp_rst_mis", {63'h0, misal}, 64'h0);
        rst = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h5555_5555;
        #1;
        check_eq("late_rv_req", {63'h0, dreq}, 64'h0);
        tick();
        check_eq("late_rv_vld", {63'h0, wb_vld}, 64'h0);
        vld = 1'b1; rden = 1'b1; f3 = 3'b010; alu = 32'h300; gnt = 1'b1; rvalid = 1'b1;
        #1;
        check_eq("idle_rv_stall", {63'h0, stall}, 64'h1);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_1111;
        tick();
        idle32();
        check_eq("post_rst_ld", {32'h0, wb_ld}, 64'h1111);
        check_eq("post_rst_vld", {63'h0, wb_vld}, 64'h1);

        // 64-bit: ld at 0x8 returns full rdata, lw at 0xC sign-extends upper word
        d_vld = 1'b1; d_rden = 1'b1; d_f3 = 3'b011; d_alu = 64'h8; d_gnt = 1'b1;
        #1;
        check_eq("ld64_addr", d_daddr, 64'h8);
        check_eq("ld64_bmask", {56'h0, d_dbm}, 64'hFF);
        check_eq("ld64_stall", {63'h0, d_stall}, 64'h1);
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1; d_rdata = 64'h8123_4567_89AB_CDEF;
        #1;
        check_eq("ld64_done", {63'h0, d_stall}, 64'h0);
        tick();
        d_rvalid = 1'b0;
        check_eq("ld64_data", d_wb_ld, 64'h8123_4567_89AB_CDEF);
        check_eq("ld64_vld", {63'h0, d_wb_vld}, 64'h1);
        d_f3 = 3'b010; d_alu = 64'hC; d_gnt = 1'b1;
        #1;
        check_eq("lw64_addr", d_daddr, 64'h8);
        check_eq("lw64_bmask", {56'h0, d_dbm}, 64'hF0);
        tick();
        d_gnt = 1'b0; d_rvalid = 1'b1;
        tick();
        d_vld = 1'b0; d_rden = 1'b0; d_rvalid = 1'b0;
        check_eq("lw64_data", d_wb_ld, 64'hFFFF_FFFF_8123_4567);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised MEM pipeline stage that talks to an external data memory over a request/grant/response handshake with variable latency. It replaces fixed single-cycle LSU access with a stall-capable stage: it steers load and store lanes, sign- or zero-extends load data, detects misaligned accesses and bus timeouts, and registers everything into the MEM/WB boundary. It sits between the execute stage and writeback, and drives the stall request for the hazard unit.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
MAX_WAIT, 15, cycles allowed in REQ+RSP before abort; must be >= 2.
CNT_W, $clog2(MAX_WAIT+1), width of the wait counter.

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_mem_insn_vld  in  1  instruction from EX is valid
i_mem_pc  in  XLEN  instruction PC
i_mem_inst  in  32  instruction word
i_mem_alu_data  in  XLEN  effective address / ALU result
i_mem_rs2_data  in  XLEN  store data
i_mem_lsu_wren  in  1  store
i_mem_lsu_rden  in  1  load
i_mem_slt_sl  in  3  funct3 size/sign: 000 b, 001 h, 010 w, 011 d (XLEN=64 only), 100 bu, 101 hu, 110 wu (XLEN=64 only)
i_mem_wb_sel  in  2  writeback select (pass-through)
i_mem_rd_wren  in  1  register write enable (pass-through)
o_dmem_req  out  1  bus request
o_dmem_we  out  1  bus write
o_dmem_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits zero)
o_dmem_wdata  out  XLEN  lane-replicated store data
o_dmem_bmask  out  XLEN/8  byte enables
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  XLEN  read data
o_mem_stall  out  1  hold EX/MEM and earlier stages
o_mem_rd_addr_fwd  out  5  i_mem_inst[11:7], combinational
o_mem_misalign  out  1  sticky misaligned-access flag
o_mem_timeout  out  1  sticky bus-timeout flag
o_wb_pc_add4, o_wb_alu_data, o_wb_ld_data, o_wb_pc_debug  out  XLEN  registered
o_wb_inst  out  32  registered
o_wb_sel  out  2  registered
o_wb_rd_wren, o_wb_insn_vld  out  1  registered

Behaviour:
- Reset (async, i_reset=1): FSM returns to IDLE, wait counter is 0, and all registered outputs and both sticky flags are 0. Any in-flight transaction is dropped. An rvalid that arrives later while in IDLE is ignored.
- Access condition: acc = i_mem_insn_vld & (lsu_wren | lsu_rden) & aligned. Aligned means h: addr[0]=0; w: addr[1:0]=0; d: addr[2:0]=0.
- Misaligned access: no bus request is issued and o_mem_misalign is set (sticky). The instruction retires the next cycle with o_wb_insn_vld=0 and o_wb_rd_wren=0. There is no stall.
- FSM IDLE / REQ / RSP:
  - o_dmem_req = (IDLE & acc) | REQ.
  - IDLE & acc & !gnt -> REQ. IDLE or REQ with gnt: a load goes to RSP; a store completes and goes to IDLE.
  - RSP & rvalid -> IDLE (load completes).
- Bus fields (addr, we, wdata, bmask) are combinational from the stage inputs. They hold steady while stalled because upstream is frozen.
- Wait counter increments each cycle in REQ or RSP and clears on entry to IDLE. When it reaches MAX_WAIT, the access aborts to IDLE, o_mem_timeout is set (sticky), and the instruction completes with ld_data=0.
- o_mem_stall = acc & !complete_this_cycle. A non-memory instruction never stalls.
- MEM/WB register updates every cycle:
  - On completion or non-access: capture pc+4, alu_data, inst, wb_sel, rd_wren, insn_vld, pc, and extracted load data.
  - While stalled: insert a bubble (insn_vld=0, rd_wren=0, other fields don't-care but held).
- Latency: non-memory instruction is 1 cycle to WB. Store with gnt in the same cycle is 1 cycle. Load with gnt at cycle 0 and rvalid at cycle 1 completes at cycle 1, with WB valid at cycle 2 (1 stall cycle).
- Load extract: byte/half/word selected by the low address bits from rdata, then sign- or zero-extended to XLEN.
- Store: data replicated across lanes. bmask is b: 1<<a, h: 3<<a, w: 4'hF<<a, d: all ones.
- rvalid while in REQ is ignored. A simultaneous abort and rvalid: rvalid wins (normal completion, no timeout).

Decomposition:
- mem_pkg: funct3 size enum, FSM state enum, helper function bmask_f(size, addr_lo).
- One sub-module, lsu_align (combinational), containing store lane steering/bmask and load extract/extend, parametrised by XLEN.
- FSM, counter, and MEM/WB register live in mem_stage_hs.

Test Plan:
1. ALU op with no memory access, alu_data=0x1234 -> o_mem_stall=0 throughout; next cycle o_wb_alu_data=0x1234, o_wb_insn_vld=1.
2. lb at addr 0x103, gnt at cycle 0, rvalid at cycle 2, rdata=0x80FF_FF00 -> stall for cycles 0-1; o_wb_ld_data=0xFFFF_FF80 one cycle after rvalid.
3. sh at 0x102 with rs2=0xABCD and gnt delayed 3 cycles -> req held 4 cycles with we=1, bmask=4'b1100, wdata=0xABCD_ABCD; 3 stall cycles.
4. lw at 0x101 -> o_dmem_req stays 0, o_mem_misalign=1, o_wb_rd_wren=0 next cycle, no stall.
5. Load with gnt but no rvalid, MAX_WAIT=15 -> abort after 15 wait cycles, o_mem_timeout=1, ld_data=0, stall released.
6. Assert reset during RSP, then rvalid pulses after release -> state IDLE, no WB valid, rvalid ignored. Also, with XLEN=64, ld at 0x8 returns the full 64-bit rdata.
